// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared sizing and FSM state encoding for the layer-2 sequencer
package nn_pkg;

  localparam int N_HIDDEN = 200;
  localparam int N_OUT    = 10;
  localparam int DW       = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_ACT,
    FETCH,
    DRAIN,
    ARGMAX,
    DONE
  } state_t;

endpackage

// File: rtl/argmax_seq.sv
// rtl/argmax_seq.sv - sequential signed argmax over the accumulator bus, one compare per cycle
module argmax_seq #(
  parameter int N_OUT = nn_pkg::N_OUT,
  parameter int DW    = nn_pkg::DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_OUT*DW-1:0] acc_bus,
  output logic                done,
  output logic [3:0]          index
);
  import nn_pkg::*;

  localparam logic [3:0] LAST = 4'(N_OUT - 1);
  localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] acc [N_OUT];
  logic signed [DW-1:0] best_val;
  logic [3:0]           best_idx;
  logic [3:0]           cnt;
  logic                 running;
  logic                 take;

  for (genvar i = 0; i < N_OUT; i++) begin : g_unpack
    assign acc[i] = acc_bus[i*DW +: DW];
  end

  // Strict greater-than keeps the earliest index on ties; entry 0 always wins
  // against the seed because best_idx starts at 0.
  assign take  = acc[cnt] > best_val;
  assign done  = running && (cnt == LAST);
  assign index = take ? cnt : best_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      running  <= 1'b0;
      cnt      <= '0;
      best_idx <= '0;
      best_val <= MOST_NEG;
    end else if (start) begin
      running  <= 1'b1;
      cnt      <= '0;
      best_idx <= '0;
      best_val <= MOST_NEG;
    end else if (running) begin
      if (take) begin
        best_val <= acc[cnt];
        best_idx <= cnt;
      end
      if (cnt == LAST) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/layer2_sequencer.sv
// rtl/layer2_sequencer.sv - sequences hidden activations and weight reads into the output MACs, then argmax
module layer2_sequencer #(
  parameter int N_HIDDEN = nn_pkg::N_HIDDEN,
  parameter int N_OUT    = nn_pkg::N_OUT,
  parameter int DW       = nn_pkg::DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                act_valid,
  input  logic [DW-1:0]       act_data,
  output logic                act_ready,
  output logic                w_re,
  output logic [7:0]          w_addr_row,
  output logic [3:0]          w_addr_col,
  output logic                mac_clear,
  output logic                mac_en,
  output logic [3:0]          mac_sel,
  output logic [DW-1:0]       act_q,
  input  logic [N_OUT*DW-1:0] acc_bus,
  output logic                busy,
  output logic                done,
  output logic [3:0]          class_out
);
  import nn_pkg::*;

  localparam logic [7:0] ROW_LAST = 8'(N_HIDDEN - 1);
  localparam logic [3:0] COL_LAST = 4'(N_OUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] row;
  logic [3:0] col;
  logic       am_start;
  logic       am_done;
  logic [3:0] am_index;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    act_ready = 1'b0;
    w_re      = 1'b0;
    mac_clear = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    am_start  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        mac_clear = 1'b1;
        state_nxt = WAIT_ACT;
      end
      WAIT_ACT: begin
        act_ready = 1'b1;
        if (act_valid) state_nxt = FETCH;
      end
      FETCH: begin
        w_re = 1'b1;
        if (col == COL_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (row == ROW_LAST) begin
          am_start  = 1'b1;
          state_nxt = ARGMAX;
        end else begin
          state_nxt = WAIT_ACT;
        end
      end
      ARGMAX: begin
        if (am_done) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign w_addr_row = row;
  assign w_addr_col = col;

  // The weight SRAM answers one cycle after w_re, so the MAC strobe is the
  // read strobe delayed by one register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      act_q     <= '0;
      mac_en    <= 1'b0;
      mac_sel   <= '0;
      class_out <= '0;
    end else begin
      mac_en  <= w_re;
      mac_sel <= col;
      case (state)
        CLEAR: row <= '0;
        WAIT_ACT: begin
          if (act_valid) begin
            act_q <= act_data;
            col   <= '0;
          end
        end
        FETCH: begin
          if (col != COL_LAST) col <= col + 4'd1;
        end
        DRAIN: begin
          if (row != ROW_LAST) row <= row + 8'd1;
        end
        ARGMAX: begin
          if (am_done) class_out <= am_index;
        end
        default: ;
      endcase
    end
  end

  argmax_seq #(
    .N_OUT (N_OUT),
    .DW    (DW)
  ) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .start   (am_start),
    .acc_bus (acc_bus),
    .done    (am_done),
    .index   (am_index)
  );

endmodule

// File: tb/tb_layer2_sequencer.sv
// tb/tb_layer2_sequencer.sv - randomized self-checking bench for layer2_sequencer
module tb_layer2_sequencer;
  localparam int N_HIDDEN = 200;
  localparam int N_OUT    = 10;
  localparam int DW       = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                act_valid;
  logic [DW-1:0]       act_data;
  logic                act_ready;
  logic                w_re;
  logic [7:0]          w_addr_row;
  logic [3:0]          w_addr_col;
  logic                mac_clear;
  logic                mac_en;
  logic [3:0]          mac_sel;
  logic [DW-1:0]       act_q;
  logic [N_OUT*DW-1:0] acc_bus;
  logic                busy;
  logic                done;
  logic [3:0]          class_out;

  layer2_sequencer #(.N_HIDDEN(N_HIDDEN), .N_OUT(N_OUT), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .act_valid  (act_valid),
    .act_data   (act_data),
    .act_ready  (act_ready),
    .w_re       (w_re),
    .w_addr_row (w_addr_row),
    .w_addr_col (w_addr_col),
    .mac_clear  (mac_clear),
    .mac_en     (mac_en),
    .mac_sel    (mac_sel),
    .act_q      (act_q),
    .acc_bus    (acc_bus),
    .busy       (busy),
    .done       (done),
    .class_out  (class_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Environment: weight SRAM with 1-cycle read and the MAC bank it feeds.
  logic signed [DW-1:0] wmem   [N_HIDDEN][N_OUT];
  logic signed [DW-1:0] acts   [N_HIDDEN];
  logic signed [DW-1:0] acc_m  [N_OUT];
  logic signed [DW-1:0] exp_acc[N_OUT];
  logic signed [DW-1:0] forced [N_OUT];
  logic signed [DW-1:0] w_q;
  logic                 use_forced = 1'b0;

  always @(posedge clk) begin
    if (w_re) w_q <= wmem[w_addr_row][w_addr_col];
    if (mac_clear) begin
      for (int i = 0; i < N_OUT; i++) acc_m[i] <= '0;
    end else if (mac_en) begin
      acc_m[mac_sel] <= acc_m[mac_sel] + $signed(act_q) * w_q;
    end
  end

  always_comb begin
    acc_bus = '0;
    for (int i = 0; i < N_OUT; i++) acc_bus[i*DW +: DW] = use_forced ? forced[i] : acc_m[i];
  end

  // Reference: row-major sweep, k-th MAC is (row k/N_OUT, col k%N_OUT).
  int mac_k, wre_k, clr_cnt, done_cnt, cyc, last_mac_cyc, done_cyc;
  always @(negedge clk) begin
    cyc++;
    if (mac_en) begin
      check("mac_sel", 32'(mac_sel), 32'(mac_k % N_OUT));
      check("act_q", 32'(act_q),
            32'($unsigned(acts[(mac_k / N_OUT < N_HIDDEN) ? mac_k / N_OUT : N_HIDDEN - 1])));
      mac_k++;
      last_mac_cyc = cyc;
    end
    if (w_re) begin
      check("w_addr_row", 32'(w_addr_row), 32'(wre_k / N_OUT));
      check("w_addr_col", 32'(w_addr_col), 32'(wre_k % N_OUT));
      wre_k++;
    end
    if (mac_clear) clr_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic void compute_expected();
    for (int c = 0; c < N_OUT; c++) begin
      int s = 0;
      for (int r = 0; r < N_HIDDEN; r++) s += int'(acts[r]) * int'(wmem[r][c]);
      exp_acc[c] = DW'(s);
    end
  endfunction

  function automatic logic [3:0] ref_argmax(input logic signed [DW-1:0] v [N_OUT]);
    int best = 0;
    for (int i = 1; i < N_OUT; i++) if (v[i] > v[best]) best = i;
    return 4'(best);
  endfunction

  task automatic randomize_data();
    for (int r = 0; r < N_HIDDEN; r++) begin
      acts[r] = DW'(int'($urandom_range(0, 15)) - 8);
      for (int c = 0; c < N_OUT; c++) wmem[r][c] = DW'(int'($urandom_range(0, 15)) - 8);
    end
  endtask

  task automatic run_inference(input int stall_row, input int stall_len, input int glitch_row,
                               input int reset_row, input logic [3:0] exp_class);
    int feed = 0;
    int stalled = 0;
    int guard = 0;
    bit glitched = 0;
    bit aborted = 0;
    bit seen_done = 0;
    mac_k = 0; wre_k = 0; clr_cnt = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!seen_done && !aborted && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (done) seen_done = 1;
      act_valid = 1'b0;
      act_data  = DW'($urandom);
      start     = 1'b0;
      if (act_ready && feed < N_HIDDEN) begin
        if (feed == stall_row && stalled < stall_len) begin
          stalled++;
          check("stall_quiet", 32'({act_ready, w_re, mac_en}), 32'(3'b100));
        end else if ($urandom_range(0, 3) != 0) begin
          act_valid = 1'b1;
          act_data  = acts[feed];
          feed++;
        end
      end else if (!act_ready) begin
        act_valid = 1'($urandom_range(0, 1));
      end
      if (w_re && w_addr_row == 8'(glitch_row) && !glitched) begin
        start    = 1'b1;
        glitched = 1;
      end
      if (w_re && w_addr_row == 8'(reset_row)) begin
        reset   = 1'b1;
        aborted = 1;
      end
    end
    act_valid = 1'b0;
    start     = 1'b0;
    if (aborted) begin
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_strobes", 32'({w_re, mac_en, mac_clear, act_ready, done}), 32'd0);
      check("abort_class", 32'(class_out), 32'd0);
      check("abort_act_q", 32'(act_q), 32'd0);
      check("abort_addr", 32'({w_addr_row, w_addr_col}), 32'd0);
      reset = 1'b0;
      repeat (30) begin
        @(negedge clk);
        check("abort_quiet", 32'({mac_en, done, busy}), 32'd0);
      end
    end else begin
      check("done_seen", 32'(seen_done), 32'd1);
      check("class_out", 32'(class_out), 32'(exp_class));
      repeat (15) @(negedge clk);
      check("mac_count", 32'(mac_k), 32'(N_HIDDEN * N_OUT));
      check("wre_count", 32'(wre_k), 32'(N_HIDDEN * N_OUT));
      check("clear_count", 32'(clr_cnt), 32'd1);
      check("done_count", 32'(done_cnt), 32'd1);
      check("done_latency", 32'(done_cyc - last_mac_cyc), 32'(N_OUT + 1));
      check("class_held", 32'(class_out), 32'(exp_class));
      check("idle_after", 32'(busy), 32'd0);
      if (!use_forced) begin
        for (int c = 0; c < N_OUT; c++) check("acc_value", 32'(acc_m[c]), 32'(exp_acc[c]));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; act_valid = 1'b0; act_data = '0;
    for (int r = 0; r < N_HIDDEN; r++) begin
      acts[r] = 16'sd1;
      for (int c = 0; c < N_OUT; c++) wmem[r][c] = DW'(c);
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({w_re, mac_en, mac_clear, act_ready, done}), 32'd0);
    check("rst_class", 32'(class_out), 32'd0);
    check("rst_act_q", 32'(act_q), 32'd0);
    check("rst_addr", 32'({w_addr_row, w_addr_col}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    compute_expected();
    run_inference(-1, 0, -1, -1, 4'd9);

    randomize_data();
    compute_expected();
    run_inference(50, 20, 10, -1, ref_argmax(exp_acc));

    use_forced = 1'b1;
    for (int i = 0; i < N_OUT; i++) forced[i] = '0;
    forced[3] = 16'sh0100;
    forced[7] = 16'sh0100;
    run_inference(-1, 0, -1, -1, 4'd3);

    for (int i = 0; i < N_OUT; i++) forced[i] = DW'(-int'($urandom_range(2, 30000)));
    forced[5] = -16'sd1;
    run_inference(-1, 0, -1, -1, 4'd5);
    use_forced = 1'b0;

    randomize_data();
    compute_expected();
    run_inference(-1, 0, -1, 100, 4'd0);

    randomize_data();
    compute_expected();
    run_inference(-1, 0, -1, -1, ref_argmax(exp_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
